// File: rtl/linear_interp.sv
// rtl/linear_interp.sv - sample-rate upconverter with linear interpolation
//
// Takes low-rate unsigned samples through a one-entry valid/ready buffer and
// emits 2^N linearly interpolated points per input interval, one per step.
//
// Ports:
//   clk, reset_n       clock, synchronous active-low reset
//   din, din_valid     input sample and its valid flag
//   din_ready          block can accept din this cycle
//   tick               output step request
//   dout, dout_valid   registered interpolated sample, one-cycle update pulse
//   underflow          sticky, set when a wrap step found no next sample
//
// Optional feature macro: LINEAR_INTERP_TICK_EDGE_EN
//   defined   : one step per rising edge of tick
//   undefined : every cycle with tick high is one step

module linear_interp #(
  parameter int N    = 4,
  parameter int BITS = 11
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [BITS:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic          tick,
  output logic [BITS:0] dout,
  output logic          dout_valid,
  output logic          underflow
);

  localparam int W  = BITS + 1;
  localparam int AW = BITS + N + 2;

  typedef enum logic [1:0] {EMPTY, PRIME, RUN, STARVE} state_t;

  state_t state, state_next;

  // prev is never stored on its own: it is the starting point loaded into acc.
  logic [BITS:0]          curr;
  logic [BITS:0]          nxt;
  logic                   nxt_valid;
  logic signed [BITS+1:0] delta;
  logic signed [AW-1:0]   acc;
  logic [N-1:0]           k;

  logic          step;
  logic          accept;
  logic          wrap;
  logic          have_next;
  logic          load;
  logic [BITS:0] load_sample;
  logic [AW-1:0] delta_ext;

`ifdef LINEAR_INTERP_TICK_EDGE_EN
  logic tick_d;

  always_ff @(posedge clk) begin
    if (!reset_n) tick_d <= 1'b0;
    else          tick_d <= tick;
  end

  assign step = tick & ~tick_d;
`else
  assign step = tick;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    din_ready   = 1'b1;
    load        = 1'b0;
    load_sample = din;
    if (state == RUN) din_ready = ~nxt_valid;
    accept    = din_valid & din_ready;
    wrap      = (state == RUN) & step & (k == '1);
    // In RUN, din_ready is low whenever nxt is full, so an accept at a wrap is the bypass.
    have_next = nxt_valid | accept;
    case (state)
      EMPTY:  if (accept) state_next = PRIME;
      PRIME:  if (accept) begin state_next = RUN; load = 1'b1; end
      RUN: begin
        if (wrap) begin
          if (have_next) begin
            load = 1'b1;
            if (nxt_valid) load_sample = nxt;
          end else begin
            state_next = STARVE;
          end
        end
      end
      STARVE: if (accept) begin state_next = RUN; load = 1'b1; end
      default: state_next = EMPTY;
    endcase
  end

  assign delta_ext = {{N{delta[BITS+1]}}, delta};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      curr       <= '0;
      nxt        <= '0;
      nxt_valid  <= 1'b0;
      delta      <= '0;
      acc        <= '0;
      k          <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      dout_valid <= 1'b0;

      if (state == RUN && step) begin
        // acc stays between prev<<N and curr<<N, so the slice is exact.
        dout       <= acc[N +: W];
        dout_valid <= 1'b1;
        if (!wrap) begin
          acc <= acc + $signed(delta_ext);
          k   <= k + 1'b1;
        end
      end

      if (state == EMPTY && accept) curr <= din;

      if (load) begin
        curr  <= load_sample;
        delta <= $signed({1'b0, load_sample}) - $signed({1'b0, curr});
        acc   <= {1'b0, curr, {N{1'b0}}};
        k     <= '0;
      end

      if (wrap) begin
        nxt_valid <= 1'b0;
      end else if (state == RUN && accept) begin
        nxt       <= din;
        nxt_valid <= 1'b1;
      end

      if (wrap && !have_next) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_linear_interp.sv
// tb/tb_linear_interp.sv - self-checking bench for linear_interp
//
// Table vectors, hand sequences and random stimulus checked against a
// sample-list reference model. Honours LINEAR_INTERP_TICK_EDGE_EN.

module tb_linear_interp;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic        tick = 1'b0;
  logic [11:0] dout;
  logic        dout_valid;
  logic        underflow;

  linear_interp #(.N(4), .BITS(11)) dut (
    .clk(clk), .reset_n(reset_n),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .tick(tick), .dout(dout), .dout_valid(dout_valid), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the list of accepted samples and the number of points
  // emitted so far fully determine the expected outputs.
  int samples[$];
  int outs[$];
  int j = 0;
  int exp_dout = 0;
  bit uf = 1'b0;
  bit prev_tick = 1'b0;

  typedef struct {
    int a;
    int b;
    int k;
    int exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic do_reset(input bit t);
    reset_n = 1'b0; din_valid = 1'b0; din = '0; tick = t;
    @(posedge clk); #1;
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_din_ready", din_ready, 1);
    chk("rst_underflow", underflow, 0);
    reset_n = 1'b1;
    samples.delete(); outs.delete();
    j = 0; exp_dout = 0; uf = 1'b0; prev_tick = 1'b0;
  endtask

  task automatic cycle(input bit v, input int d, input bit t, output bit took);
    bit step, prod, ready;
    int i, k, a, b;
    din_valid = v; din = d[11:0]; tick = t;
    #1;
    ready = (samples.size() < j / 16 + 3);
    chk("din_ready", din_ready, ready);
    took = v && ready;
`ifdef LINEAR_INTERP_TICK_EDGE_EN
    step = t && !prev_tick;
`else
    step = t;
`endif
    prev_tick = t;
    prod = step && (samples.size() >= j / 16 + 2);
    if (took) samples.push_back(d);
    if (prod) begin
      i = j / 16; k = j % 16;
      a = samples[i]; b = samples[i + 1];
      exp_dout = (16 * a + (b - a) * k) / 16;
      if (k == 15 && samples.size() < i + 3) uf = 1'b1;
      j++;
    end
    @(posedge clk); #1;
    chk("dout_valid", dout_valid, prod);
    chk("dout", dout, exp_dout);
    chk("underflow", underflow, uf);
    if (dout_valid) outs.push_back(dout);
  endtask

  task automatic put(input int d);
    bit x;
    cycle(1'b1, d, 1'b0, x);
  endtask

  task automatic tstep();
    bit x;
    cycle(1'b0, 0, 1'b1, x);
    cycle(1'b0, 0, 1'b0, x);
  endtask

  initial begin
    bit x, taken;
    int low_cycles, tick_pct;

    vecs[0]  = '{a: 0,    b: 160,  k: 0,  exp: 0};
    vecs[1]  = '{a: 0,    b: 160,  k: 5,  exp: 50};
    vecs[2]  = '{a: 0,    b: 160,  k: 15, exp: 150};
    vecs[3]  = '{a: 1600, b: 0,    k: 0,  exp: 1600};
    vecs[4]  = '{a: 1600, b: 0,    k: 15, exp: 100};
    vecs[5]  = '{a: 0,    b: 5,    k: 3,  exp: 0};
    vecs[6]  = '{a: 0,    b: 5,    k: 4,  exp: 1};
    vecs[7]  = '{a: 0,    b: 5,    k: 12, exp: 3};
    vecs[8]  = '{a: 0,    b: 5,    k: 15, exp: 4};
    vecs[9]  = '{a: 4095, b: 0,    k: 1,  exp: 3839};
    vecs[10] = '{a: 0,    b: 4095, k: 15, exp: 3839};
    vecs[11] = '{a: 100,  b: 101,  k: 15, exp: 100};

    do_reset(1'b0);

    for (int r = 0; r < 12; r++) begin
      do_reset(1'b0);
      put(vecs[r].a);
      put(vecs[r].b);
      for (int s = 0; s <= vecs[r].k; s++) tstep();
      chk($sformatf("vec%0d", r), dout, vecs[r].exp);
    end

    // Reset in the middle of RUN with tick held high.
    do_reset(1'b0);
    put(0); put(160); tstep(); tstep();
    do_reset(1'b1);
    cycle(1'b1, 0, 1'b1, x);
    cycle(1'b1, 160, 1'b1, x);
    chk("mid_reset_no_out", outs.size(), 0);
    tstep();
    chk("mid_reset_first", dout, 0);

    // Two full ramps, then underflow.
    do_reset(1'b0);
    put(0); put(160); put(320);
    for (int s = 0; s < 34; s++) tstep();
    chk("ramp_count", outs.size(), 32);
    for (int s = 0; s < 32 && s < outs.size(); s++) chk("ramp_val", outs[s], 10 * s);
    chk("ramp_underflow", underflow, 1);

    // Falling ramp, dout holds the last point.
    do_reset(1'b0);
    put(1600); put(0);
    for (int s = 0; s < 18; s++) tstep();
    chk("fall_count", outs.size(), 16);
    chk("fall_last", outs[outs.size() - 1], 100);
    chk("fall_hold", dout, 100);
    chk("fall_underflow", underflow, 1);

    // Starve, then resume continuously.
    do_reset(1'b0);
    put(0); put(160);
    for (int s = 0; s < 20; s++) tstep();
    chk("starve_count", outs.size(), 16);
    chk("starve_underflow", underflow, 1);
    put(320);
    tstep();
    chk("resume_val", dout, 160);
    tstep();
    chk("resume_next", dout, 170);

    // Held offer of 777 while nxt is full.
    do_reset(1'b0);
    put(0); put(160); put(320);
    taken = 1'b0; low_cycles = 0;
    for (int s = 0; s < 40; s++) begin
      if (!taken && !din_ready) low_cycles++;
      cycle(!taken, 777, 1'b1, x);
      if (x) taken = 1'b1;
      cycle(1'b0, 0, 1'b0, x);
    end
    chk("hold_low_cycles", low_cycles, 16);
    chk("hold_sample_count", samples.size(), 4);
    chk("hold_out32", outs[32], 320);
    chk("hold_out33", outs[33], 348);

    // Five-cycle tick strobe.
    do_reset(1'b0);
    put(0); put(160);
    for (int s = 0; s < 5; s++) cycle(1'b0, 0, 1'b1, x);
    cycle(1'b0, 0, 1'b0, x);
    cycle(1'b0, 0, 1'b0, x);
`ifdef LINEAR_INTERP_TICK_EDGE_EN
    chk("strobe_pulses", outs.size(), 1);
`else
    chk("strobe_pulses", outs.size(), 5);
`endif

    // Randomized run against the model.
    do_reset(1'b0);
    tick_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) tick_pct = $urandom_range(10, 95);
      if (c == 1500) do_reset(1'b1);
      cycle(($urandom_range(0, 99) < 40), $urandom_range(0, 4095),
            ($urandom_range(0, 99) < tick_pct), x);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
